xalu_sequencer: RTL and testbench
=================================

Name: xalu_sequencer

Overview:
- Controller for the E-stage multiply/divide resource. Accepts one HI/LO-class operation at a time, sequences a pipelined multiplier and a 32-step radix-2 restoring divider, and owns the architectural HI/LO registers.
- Drives the busy indication that the E stage uses to park a pending instruction. Supports flush from exception or pipeline clear.

Parameters:
- MUL_CYCLES, 3, multiply latency in cycles from accept to result. Legal range 1..8.
- DIV_CYCLES, 33, divide latency: 32 iterations plus 1 sign-fix cycle. Fixed; exposed for the bench only.

Ports:
- Clk  in  1  single clock, rising edge.
- Clr  in  1  asynchronous, active-high reset.
- op_valid  in  1  operation request from E stage.
- op_code  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MUL (GPR result only), 7 reserved (ignored).
- src_a  in  32  rs operand (forwarded value).
- src_b  in  32  rt operand (forwarded value).
- flush  in  1  abort in-flight operation (exception or clear).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when a MUL/DIV-class result commits.
- res_lo  out  32  low result word; valid while done=1 (used by MUL).
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (Clr=1, async): state=IDLE; busy=0; done=0; res_lo=0; hi=0; lo=0; counters=0.
- States: IDLE, MUL, DIV, FIX.
- Accept rule: op_valid sampled only in IDLE with flush=0. Requests while busy are ignored; the requester must hold op_valid until busy=0.
- MTHI/MTLO: hi (or lo) <= src_a at the accept edge. No busy, no done.
- MULT/MULTU/MUL: IDLE->MUL at accept.
  - Operands latched at accept; signed or unsigned 64-bit product.
  - busy=1 for exactly MUL_CYCLES cycles.
  - On the MUL_CYCLES-th edge after accept: state->IDLE, busy->0, done->1 for one cycle, res_lo=product[31:0].
  - MULT/MULTU also write hi=product[63:32] and lo=product[31:0]. MUL leaves hi/lo unchanged.
- DIV/DIVU: IDLE->DIV at accept.
  - Latch |a| and |b| (DIV) or raw values (DIVU), plus the quotient and remainder signs.
  - 32 iteration cycles (5-bit counter 0..31), then FIX for 1 cycle.
  - FIX negates the quotient if sign(a)^sign(b), and the remainder if sign(a), then commits lo=quotient, hi=remainder, done=1, res_lo=quotient, state->IDLE.
  - busy=1 for 33 cycles total.
- Divide by zero: run full length; commit lo=32'hFFFFFFFF and hi=src_a as latched. No exception is raised.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- flush=1 in any state: next edge state->IDLE, busy->0, no done, hi/lo unchanged. This includes the commit edge: flush wins over commit.
- flush and op_valid in the same IDLE cycle: the op is dropped, including MTHI/MTLO.
- done is never asserted in the same cycle as an accept. A new op may be accepted in the cycle done=1, since busy=0.
- Clr mid-operation: immediate return to reset values.
- hi/lo change only at MTHI/MTLO accept or at commit, never mid-iteration.

Optional Feature:
- Macro XALU_EARLY_DIV_EN.
- Defined: in the accept cycle of DIV/DIVU, if divisor magnitude > dividend magnitude, or divisor==0, skip DIV and enter FIX directly with quotient=0 and remainder=dividend (or the div-by-zero values). busy lasts 1 cycle and done pulses on the 1st edge after accept.
- Undefined: all divides take 33 cycles.

Test Plan:
- Clr pulse mid-DIV (cycle 10) -> busy=0, done=0, hi=lo=0 immediately, before any clock edge.
- MULT a=0xFFFFFFFE (-2), b=3, MUL_CYCLES=3 -> done at 3rd edge after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 -> busy 33 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- MUL a=6, b=7 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> res_lo=42 with done; hi=0x11, lo=0x22 unchanged.
- DIV in flight, flush at cycle 20 -> busy=0 next cycle, no done, hi/lo hold old values. A new op issued while busy=1 is ignored.
- DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. With XALU_EARLY_DIV_EN, DIVU a=3, b=9 -> done 1 cycle after accept, lo=0, hi=3.

Source files
------------

// File: rtl/xalu_sequencer_if.sv
// Request/response bundle between the E stage (master) and the HI/LO
// multiply/divide sequencer (slave).
interface xalu_sequencer_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] res_lo;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op_code, src_a, src_b, flush,
        input  busy, done, res_lo, hi, lo
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, flush,
        output busy, done, res_lo, hi, lo
    );
endinterface

// File: rtl/xalu_sequencer.sv
// E-stage multiply/divide sequencer: multi-cycle multiply, 32-step restoring divide, owns HI/LO.
// Optional macro XALU_EARLY_DIV_EN: divides with |b| > |a| or b == 0 jump straight to the sign-fix cycle.
module xalu_sequencer #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33
) (
    input  logic            Clk,
    input  logic            Clr,
    xalu_sequencer_if.slave xalu
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 2);

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic c);
        return c ? (~v + 32'd1) : v;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] a_q, b_q, dvs_q, quo_q, rem_q;
    logic        mul_sgn_q, mul_only_q, qneg_q, rneg_q, dz_q;

    logic        accept, is_mul, is_div, sdiv, early;
    logic [31:0] abs_a, abs_b, q_fix, r_fix;
    logic [63:0] a_ext, b_ext, prod;
    logic [32:0] shifted, trial;
    logic        trial_ok;

    assign accept = (state_q == S_IDLE) && xalu.op_valid && !xalu.flush;
    assign is_mul = (xalu.op_code == OP_MULT) || (xalu.op_code == OP_MULTU) || (xalu.op_code == OP_MUL);
    assign is_div = (xalu.op_code == OP_DIV) || (xalu.op_code == OP_DIVU);
    assign sdiv   = (xalu.op_code == OP_DIV);
    assign abs_a  = neg_if(xalu.src_a, sdiv & xalu.src_a[31]);
    assign abs_b  = neg_if(xalu.src_b, sdiv & xalu.src_b[31]);

`ifdef XALU_EARLY_DIV_EN
    assign early = (abs_b > abs_a) || (xalu.src_b == 32'd0);
`else
    assign early = 1'b0;
`endif

    // Sign-extending to 64 bits makes one modular product serve both signed and unsigned.
    assign a_ext = {{32{mul_sgn_q & a_q[31]}}, a_q};
    assign b_ext = {{32{mul_sgn_q & b_q[31]}}, b_q};
    assign prod  = a_ext * b_ext;

    assign shifted  = {rem_q, quo_q[31]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign trial_ok = !trial[32];

    assign q_fix = dz_q ? 32'hFFFF_FFFF : neg_if(quo_q, qneg_q);
    assign r_fix = dz_q ? a_q : neg_if(rem_q, rneg_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = S_MUL;
                        cnt_d   = 5'd0;
                    end else if (is_div) begin
                        state_d = early ? S_FIX : S_DIV;
                        cnt_d   = 5'd0;
                    end else if (xalu.op_code == OP_MTHI) begin
                        hi_d = xalu.src_a;
                    end else if (xalu.op_code == OP_MTLO) begin
                        lo_d = xalu.src_a;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    res_lo_d = prod[31:0];
                    if (!mul_only_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DIV: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                res_lo_d = q_fix;
                hi_d     = r_fix;
                lo_d     = q_fix;
            end
        endcase
        // Flush dominates everything, including a commit on the same edge.
        if (xalu.flush) begin
            state_d  = S_IDLE;
            cnt_d    = 5'd0;
            done_d   = 1'b0;
            res_lo_d = res_lo_q;
            hi_d     = hi_q;
            lo_d     = lo_q;
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            done_q   <= 1'b0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (accept) begin
            a_q        <= xalu.src_a;
            b_q        <= xalu.src_b;
            mul_sgn_q  <= (xalu.op_code == OP_MULT) || (xalu.op_code == OP_MUL);
            mul_only_q <= (xalu.op_code == OP_MUL);
            qneg_q     <= sdiv & (xalu.src_a[31] ^ xalu.src_b[31]);
            rneg_q     <= sdiv & xalu.src_a[31];
            dz_q       <= (xalu.src_b == 32'd0);
            dvs_q      <= abs_b;
            quo_q      <= early ? 32'd0 : abs_a;
            rem_q      <= early ? abs_a : 32'd0;
        end else if (state_q == S_DIV) begin
            rem_q <= trial_ok ? trial[31:0] : shifted[31:0];
            quo_q <= {quo_q[30:0], trial_ok};
        end
    end

    assign xalu.busy   = (state_q != S_IDLE);
    assign xalu.done   = done_q;
    assign xalu.res_lo = res_lo_q;
    assign xalu.hi     = hi_q;
    assign xalu.lo     = lo_q;
endmodule

// File: tb/tb_xalu_sequencer.sv
// Directed plus randomized bench for xalu_sequencer against an arithmetic reference model.
module tb_xalu_sequencer;
    localparam int MUL_CYCLES = 3;
    localparam int DIV_CYCLES = 33;

    logic Clk;
    logic Clr;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    xalu_sequencer_if bus ();

    xalu_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .Clk  (Clk),
        .Clr  (Clr),
        .xalu (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference: results from plain integer arithmetic, latency from the op class.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic [31:0] er, output int elat);
        logic [63:0] p, qv, rv;
        longint      sa, sb, ma, mb;
        eh = m_hi; el = m_lo; er = 32'd0; elat = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0, 3'd6: begin
                p = sa * sb;
                if (op == 3'd0) begin eh = p[63:32]; el = p[31:0]; end
                er = p[31:0];
                elat = MUL_CYCLES;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                eh = p[63:32]; el = p[31:0]; er = p[31:0];
                elat = MUL_CYCLES;
            end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else if (op == 3'd2) begin
                    qv = sa / sb; rv = sa % sb;
                    el = qv[31:0]; eh = rv[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
                er = el;
                elat = DIV_CYCLES;
                if (op == 3'd2) begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                end else begin
                    ma = longint'({32'd0, a});
                    mb = longint'({32'd0, b});
                end
`ifdef XALU_EARLY_DIV_EN
                if (b == 32'd0 || mb > ma) elat = 1;
`else
                if (mb < 0 || ma < 0) elat = 0;
`endif
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el, er;
        int          elat, lat;
        model(op, a, b, eh, el, er, elat);
        bus.op_valid = 1'b1; bus.op_code = op; bus.src_a = a; bus.src_b = b;
        step();
        bus.op_valid = 1'b0;
        if (elat == 0) begin
            chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
            chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        end else begin
            chk({tag, "_busy_start"}, {31'd0, bus.busy}, 32'd1);
            lat = 0;
            while (bus.done !== 1'b1 && lat < 60) begin
                if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
                    chk({tag, "_inflight"}, {bus.busy, 31'd0} ^ bus.hi ^ bus.lo, {1'b1, 31'd0} ^ m_hi ^ m_lo);
                step();
                lat++;
            end
            chk({tag, "_latency"}, lat, elat);
            chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
            chk({tag, "_res_lo"}, bus.res_lo, er);
        end
        chk({tag, "_hi"}, bus.hi, eh);
        chk({tag, "_lo"}, bus.lo, el);
        m_hi = eh; m_lo = el;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] tbl [6];
        tbl = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        case ($urandom_range(0, 3))
            0: return tbl[$urandom_range(0, 5)];
            1: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dcnt;
        Clr = 1'b1;
        bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.flush = 1'b0;
        repeat (2) step();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_res_lo", bus.res_lo, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        Clr = 1'b0;
        step();

        do_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
        do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
        do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        do_op("divu", 3'd3, 32'd100, 32'd7);
        do_op("mthi", 3'd4, 32'h11, 32'd0);
        do_op("mtlo", 3'd5, 32'h22, 32'd0);
        do_op("mul_gpr", 3'd6, 32'd6, 32'd7);
        do_op("divu_zero", 3'd3, 32'd5, 32'd0);
        do_op("div_zero_neg", 3'd2, 32'hFFFF_FFF0, 32'd0);
        do_op("divu_small", 3'd3, 32'd3, 32'd9);
        do_op("div_small_neg", 3'd2, 32'hFFFF_FFFD, 32'd9);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("reserved", 3'd7, 32'h1234, 32'h5678);

        // Flush of an in-flight divide, with a request issued while busy.
        bus.op_valid = 1'b1; bus.op_code = 3'd2; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        step();
        bus.op_valid = 1'b0;
        chk("flush_busy_start", {31'd0, bus.busy}, 32'd1);
        repeat (4) step();
        bus.op_valid = 1'b1; bus.op_code = 3'd4; bus.src_a = 32'hDEAD_BEEF;
        repeat (3) step();
        bus.op_valid = 1'b0;
        repeat (12) step();
        chk("busy_ignore_hi", bus.hi, m_hi);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_done", {31'd0, bus.done}, 32'd0);
        chk("flush_hi", bus.hi, m_hi);
        chk("flush_lo", bus.lo, m_lo);
        dcnt = 0;
        repeat (40) begin
            if (bus.done === 1'b1) dcnt++;
            step();
        end
        chk("flush_no_done", dcnt, 0);
        chk("flush_hi_after", bus.hi, m_hi);

        // Flush together with a request in IDLE drops the request.
        bus.op_valid = 1'b1; bus.op_code = 3'd4; bus.src_a = 32'hCAFE_0001; bus.flush = 1'b1;
        step();
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_mthi_hi", bus.hi, m_hi);
        chk("flush_mthi_busy", {31'd0, bus.busy}, 32'd0);

        // Flush on the commit edge wins.
        bus.op_valid = 1'b1; bus.op_code = 3'd0; bus.src_a = 32'd9; bus.src_b = 32'd9;
        step();
        bus.op_valid = 1'b0;
        repeat (MUL_CYCLES - 1) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_commit_done", {31'd0, bus.done}, 32'd0);
        chk("flush_commit_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_commit_lo", bus.lo, m_lo);

        // Asynchronous clear in the middle of a divide.
        bus.op_valid = 1'b1; bus.op_code = 3'd3; bus.src_a = 32'd100; bus.src_b = 32'd7;
        step();
        bus.op_valid = 1'b0;
        repeat (9) step();
        Clr = 1'b1;
        #1;
        chk("clr_busy", {31'd0, bus.busy}, 32'd0);
        chk("clr_done", {31'd0, bus.done}, 32'd0);
        chk("clr_hi", bus.hi, 32'd0);
        chk("clr_lo", bus.lo, 32'd0);
        #2;
        Clr = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        step();

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
